// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM encoding and opcode legality check for the multi-cycle ALU
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_BLT  = 4'd11;
    localparam logic [3:0] OP_BLTU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_BLTU);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - shift-add multiplier, one multiplier bit per cycle, low DW bits of a*b
module alu_mul_iter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          done,
    output logic [DW-1:0] prod
);

    localparam int CW = $clog2(DW);

    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplr_q, mplr_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic [DW-1:0] step_sum;

    // The last bit is folded in combinationally so the product is ready on the DW-th edge.
    always_comb begin
        step_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
        done     = run_q && (cnt_q == CW'(DW - 1));
        prod     = step_sum;
    end

    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        if (flush) begin
            mcand_d = '0;
            mplr_d  = '0;
            acc_d   = '0;
            cnt_d   = '0;
            run_d   = 1'b0;
        end else if (start) begin
            mcand_d = a;
            mplr_d  = b;
            acc_d   = '0;
            cnt_d   = '0;
            run_d   = 1'b1;
        end else if (run_q) begin
            acc_d   = step_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            run_d   = !done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with valid/ready channels, iterative multiply and flush
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int IMMW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [IMMW-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   result,
    output logic            taken,
    output logic            err,
    output logic            busy
);

    localparam int SHW = $clog2(DW);

    state_t        state_q, state_d;
    logic [DW-1:0] result_q, result_d;
    logic          taken_q, taken_d;
    logic          err_q, err_d;

    logic          accept;
    logic          mul_start;
    logic          mul_done;
    logic [DW-1:0] mul_prod;

    logic [SHW-1:0] shamt;
    logic [DW-1:0]  imm_sx;
    logic [DW-1:0]  alu_res;
    logic           alu_taken;
    logic           alu_err;
    logic           is_branch;
    logic           cond;

    assign in_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_iter #(.DW(DW)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        shamt     = b[SHW-1:0];
        imm_sx    = DW'($signed(imm));
        alu_res   = '0;
        is_branch = 1'b0;
        cond      = 1'b0;
        alu_err   = !is_legal_op(op);
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_BEQ:  begin is_branch = 1'b1; cond = (a == b); end
            OP_BNE:  begin is_branch = 1'b1; cond = (a != b); end
            OP_BLT:  begin is_branch = 1'b1; cond = ($signed(a) < $signed(b)); end
            OP_BLTU: begin is_branch = 1'b1; cond = (a < b); end
            default: alu_res = '0;
        endcase
        alu_taken = is_branch && cond;
        if (is_branch) begin
            alu_res = cond ? imm_sx : DW'(1);
        end
    end

    // Flush wins over everything, including a result handshake or a coincident accept.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        taken_d  = taken_q;
        err_d    = err_q;
        if (flush) begin
            state_d  = S_IDLE;
            result_d = '0;
            taken_d  = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state_d = S_MUL;
                        end else begin
                            state_d  = S_DONE;
                            result_d = alu_res;
                            taken_d  = alu_taken;
                            err_d    = alu_err;
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state_d  = S_DONE;
                        result_d = mul_prod;
                        taken_d  = 1'b0;
                        err_d    = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            taken_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            taken_q  <= taken_d;
            err_q    <= err_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL);
    assign result    = result_q;
    assign taken     = taken_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int DW   = 8;
    localparam int IMMW = 6;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic            taken, err, busy;
    logic [3:0]      op;
    logic [DW-1:0]   a, b, result;
    logic [IMMW-1:0] imm;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          tk;
        logic          er;
    } exp_t;

    exp_t exp_q[$];
    exp_t got_exp;

    always #5 clk = ~clk;

    alu_multicycle #(.DW(DW), .IMMW(IMMW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .taken     (taken),
        .err       (err),
        .busy      (busy)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                                   input logic [IMMW-1:0] im);
        exp_t            e;
        int              sh, v, sx, sy;
        logic [DW-1:0]   ones;
        logic [2*DW-1:0] p;
        logic            c;
        e    = '0;
        ones = '1;
        sh   = int'(y) % DW;
        v    = int'(im);
        if (im[IMMW-1]) v = v - (1 << IMMW);
        sx   = x[DW-1] ? int'(x) - (1 << DW) : int'(x);
        sy   = y[DW-1] ? int'(y) - (1 << DW) : int'(y);
        c    = 1'b0;
        case (o)
            4'd0: e.res = x + y;
            4'd1: e.res = x & y;
            4'd2: e.res = x | y;
            4'd3: e.res = x ^ y;
            4'd4: e.res = x - y;
            4'd5: e.res = x << sh;
            4'd6: e.res = x >> sh;
            4'd7: e.res = (x >> sh) | (x[DW-1] ? ~(ones >> sh) : '0);
            4'd8: begin p = x * y; e.res = p[DW-1:0]; end
            4'd9, 4'd10, 4'd11, 4'd12: begin
                if (o == 4'd9)  c = (x == y);
                if (o == 4'd10) c = (x != y);
                if (o == 4'd11) c = (sx < sy);
                if (o == 4'd12) c = (int'(x) < int'(y));
                e.tk  = c;
                e.res = c ? v[DW-1:0] : DW'(1);
            end
            default: e.er = 1'b1;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected result=%h taken=%b err=%b required no output", result, taken, err);
            end else begin
                got_exp = exp_q.pop_front();
                if ({result, taken, err} !== got_exp) begin
                    errors++;
                    $display("FAIL sb_result got result=%h taken=%b err=%b required result=%h taken=%b err=%b",
                             result, taken, err, got_exp.res, got_exp.tk, got_exp.er);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [IMMW-1:0] im, output int waited);
        waited = 0;
        @(negedge clk);
        op = o; a = x; b = y; imm = im; in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL issue_timeout op=%0d in_ready=%b required 1", o, in_ready);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(o, x, y, im));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = DW'($urandom); b = DW'($urandom); op = 4'($urandom_range(0, 15)); imm = IMMW'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; imm = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h required 00", result); end
        checks++; if ({taken, err} !== 2'b00) begin errors++; $display("FAIL reset_taken_err got %b required 00", {taken, err}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_add_sub();
        int w;
        issue(OP_ADD, 8'h7F, 8'h01, '0, w);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency out_valid=%b required 1", out_valid); end
        issue(OP_SUB, 8'h00, 8'h01, '0, w);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_latency out_valid=%b required 1", out_valid); end
        wait_drain();
    endtask

    task automatic test_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int w;
        issue(OP_MUL, x, y, '0, w);
        for (int k = 0; k < DW; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, in_ready, out_valid} !== 3'b100) begin
                errors++;
                $display("FAIL mul_in_flight cycle=%0d busy,in_ready,out_valid=%b required 100", k, {busy, in_ready, out_valid});
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_latency out_valid=%b required 1", out_valid); end
        wait_drain();
    endtask

    task automatic test_branch();
        int w;
        issue(OP_BLT,  8'hFF, 8'h01, 6'h3E, w);
        issue(OP_BLTU, 8'hFF, 8'h01, 6'h3E, w);
        issue(OP_BEQ,  8'h5A, 8'h5A, 6'h05, w);
        issue(OP_BNE,  8'h01, 8'h02, 6'h21, w);
        issue(OP_BEQ,  8'h01, 8'h02, 6'h21, w);
        wait_drain();
    endtask

    task automatic test_shift_illegal();
        int w;
        issue(OP_SRA, 8'h80, 8'h03, '0, w);
        issue(OP_SLL, 8'h81, 8'h01, '0, w);
        issue(OP_SRL, 8'h81, 8'h09, '0, w);
        issue(4'd14,  8'h12, 8'h34, '0, w);
        issue(OP_AND, 8'hC3, 8'h5A, '0, w);
        issue(OP_OR,  8'hC3, 8'h5A, '0, w);
        issue(4'd15,  8'hFF, 8'hFF, '0, w);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int w;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(OP_ADD, 8'h05, 8'h06, '0, w);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || result !== 8'h0B) begin
                errors++;
                $display("FAIL hold cycle=%0d out_valid,in_ready=%b result=%h required 10 0b", k, {out_valid, in_ready}, result);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(OP_XOR, 8'hF0, 8'h0F, '0, w);
        checks++; if (w != 0) begin errors++; $display("FAIL dual_handshake waited=%0d required 0", w); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 8'hFF) begin
            errors++;
            $display("FAIL after_release out_valid=%b result=%h required 1 ff", out_valid, result);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int w;
        logic [3:0] o;
        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(0, 12));
            if (o == OP_MUL) o = OP_ADD;
            issue(o, DW'($urandom), DW'($urandom), IMMW'($urandom), w);
            if (i > 0) begin
                checks++;
                if (w != 0) begin errors++; $display("FAIL back_to_back op#%0d waited=%0d required 0", i, w); end
            end
        end
        wait_drain();
    endtask

    task automatic test_flush();
        int w;
        logic seen;
        issue(OP_MUL, 8'd7, 8'd9, '0, w);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b required 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        for (int k = 0; k < DW + 3; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            if (k == 0) begin
                checks++;
                if ({in_ready, busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL flush_next in_ready,busy=%b required 10", {in_ready, busy});
                end
            end
        end
        checks++; if (seen) begin errors++; $display("FAIL flush_mul_out_valid rose=1 required 0"); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(OP_XOR, 8'h03, 8'h05, '0, w);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_hold_pre out_valid=%b required 1", out_valid); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL flush_hold out_valid=%b result=%h required 0 00", out_valid, result);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_abort();
        int w;
        logic seen;
        issue(OP_ADD, 8'h11, 8'h22, '0, w);
        wait_drain();
        issue(OP_MUL, 8'd5, 8'd6, '0, w);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, taken, err} !== 4'b0000 || result !== '0) begin
            errors++;
            $display("FAIL async_reset out_valid,busy,taken,err=%b result=%h required 0000 00",
                     {out_valid, busy, taken, err}, result);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < DW + 2; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL reset_abort_partial out_valid_or_busy=1 required 0"); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_abort_in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_random_mix();
        int w;
        for (int i = 0; i < 12; i++) begin
            issue(4'($urandom_range(0, 15)), DW'($urandom), DW'($urandom), IMMW'($urandom), w);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul(8'd13, 8'd11);
        test_mul(8'h20, 8'h10);
        test_branch();
        test_shift_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_abort();
        test_random_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
